// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared types, constants and register-match helper for hazard control
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         MULT_LAT_DEF = 4;
    localparam int         DIV_LAT_DEF  = 32;

    // $0 is hard-wired zero, so a producer writing it can never create a hazard
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst, input logic we);
        return (src != REG_ZERO) && (src == dst) && we;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_sequencer.sv
// md_sequencer: iterative mult/div occupancy FSM producing MdBusy and the HI/LO write strobe
module md_sequencer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic MdStartE,
    input  logic MdIsDivE,
    output logic MdBusy,
    output logic MdDone
);

    md_state_t          state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   load;

    // The state register already spends one cycle in DONE and one on issue, hence LAT-2
    assign load   = MdIsDivE ? CNT_W'(DIV_LAT - 2) : CNT_W'(MULT_LAT - 2);
    assign MdBusy = (state != IDLE);
    assign MdDone = (state == DONE);

    // State and countdown registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state: a start in BUSY is ignored since decode holds it back
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: if (MdStartE) begin
                cnt_n   = load;
                state_n = BUSY;
            end
            BUSY: if (cnt == '0) state_n = DONE;
                  else cnt_n = cnt - CNT_W'(1);
            DONE: if (MdStartE) begin
                cnt_n   = load;
                state_n = BUSY;
            end else state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use, branch-operand and HI/LO stall/flush control; HAZARD_PERF_EN adds stall/flush counters
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic        BranchD,
    input  logic        JumpRegD,
    input  logic        PCSrcD,
    input  logic        HiLoReadD,
    input  logic        MdStartD,
    input  logic [4:0]  WriteRegE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MdStartE,
    input  logic        MdIsDivE,
    input  logic [4:0]  WriteRegM,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic        MdBusy,
    output logic        MdDone
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
`endif
);

    logic match_e, match_m, lwstall, brstall, mdstall, stall;

    md_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_md (
        .clk      (clk),
        .rst      (rst),
        .MdStartE (MdStartE),
        .MdIsDivE (MdIsDivE),
        .MdBusy   (MdBusy),
        .MdDone   (MdDone)
    );

    // ALU results in M are forwarded to the D comparator; loads in M are not yet available
    assign match_e = reg_match(RsD, WriteRegE, RegWriteE) || reg_match(RtD, WriteRegE, RegWriteE);
    assign match_m = reg_match(RsD, WriteRegM, RegWriteM) || reg_match(RtD, WriteRegM, RegWriteM);
    assign lwstall = MemtoRegE && match_e;
    assign brstall = (BranchD || JumpRegD) && (match_e || (MemtoRegM && match_m));
    assign mdstall = (HiLoReadD || MdStartD) && (MdBusy || MdStartE);
    assign stall   = !rst && (lwstall || brstall || mdstall);

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    // A stalled branch re-resolves next cycle, so its flush waits
    assign FlushD = !rst && PCSrcD && !stall;

`ifdef HAZARD_PERF_EN
    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (stall && StallCnt != '1) StallCnt <= StallCnt + 32'd1;
            if (FlushD && FlushCnt != '1) FlushCnt <= FlushCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic       clk, rst;
    logic [4:0] RsD, RtD, WriteRegE, WriteRegM;
    logic       BranchD, JumpRegD, PCSrcD, HiLoReadD, MdStartD;
    logic       RegWriteE, MemtoRegE, MdStartE, MdIsDivE, RegWriteM, MemtoRegM;
    logic       StallF, StallD, FlushD, FlushE, MdBusy, MdDone;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    typedef struct {
        string      tag;
        logic [5:0] v;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    hazard_stall_ctrl dut (
        .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .JumpRegD(JumpRegD),
        .PCSrcD(PCSrcD), .HiLoReadD(HiLoReadD), .MdStartD(MdStartD), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MdStartE(MdStartE), .MdIsDivE(MdIsDivE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .MdBusy(MdBusy), .MdDone(MdDone)
`ifdef HAZARD_PERF_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] mk(input logic s, input logic f, input logic b, input logic d);
        return {s, s, f, s, b, d};
    endfunction

    task automatic clr();
        RsD = 0; RtD = 0; WriteRegE = 0; WriteRegM = 0;
        BranchD = 0; JumpRegD = 0; PCSrcD = 0; HiLoReadD = 0; MdStartD = 0;
        RegWriteE = 0; MemtoRegE = 0; MdStartE = 0; MdIsDivE = 0; RegWriteM = 0; MemtoRegM = 0;
    endtask

    task automatic step(input string tag, input logic [5:0] e);
        sb_t        x;
        logic [5:0] obs;
        sb.push_back('{tag, e});
        @(negedge clk);
        obs = {StallF, StallD, FlushD, FlushE, MdBusy, MdDone};
        x = sb.pop_front();
        checks++;
        assert (obs === x.v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.v);
        end
        @(posedge clk); #1;
    endtask

    task automatic lw_hazard(input logic [4:0] r);
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = r; RsD = r;
    endtask

    initial begin
        clr();
        rst = 1;
        @(posedge clk); #1;
        lw_hazard(8); HiLoReadD = 1; MdStartE = 1; PCSrcD = 1;
        step("reset_forces_zero", mk(0, 0, 0, 0));
        rst = 0;

        clr(); lw_hazard(8);
        step("lw_use_rs", mk(1, 0, 0, 0));
        clr();
        step("lw_gone", mk(0, 0, 0, 0));
        clr(); lw_hazard(0);
        step("lw_r0_no_stall", mk(0, 0, 0, 0));
        clr(); RegWriteE = 1; MemtoRegE = 1; WriteRegE = 9; RtD = 9;
        step("lw_use_rt", mk(1, 0, 0, 0));
        clr(); RegWriteE = 0; MemtoRegE = 1; WriteRegE = 9; RtD = 9;
        step("lw_no_we", mk(0, 0, 0, 0));
        clr(); RegWriteE = 1; MemtoRegE = 0; WriteRegE = 9; RtD = 9;
        step("alu_in_e_no_stall", mk(0, 0, 0, 0));

        clr(); BranchD = 1; RtD = 5; RegWriteE = 1; WriteRegE = 5;
        step("br_alu_in_e", mk(1, 0, 0, 0));
        clr(); BranchD = 1; RtD = 5; RegWriteM = 1; MemtoRegM = 1; WriteRegM = 5; PCSrcD = 1;
        step("br_lw_in_m", mk(1, 0, 0, 0));
        clr(); BranchD = 1; RtD = 5; PCSrcD = 1;
        step("br_flush_after_stall", mk(0, 1, 0, 0));
        clr(); BranchD = 1; RtD = 5; RegWriteM = 1; WriteRegM = 5;
        step("br_alu_in_m_forwarded", mk(0, 0, 0, 0));
        clr(); JumpRegD = 1; RsD = 31; RegWriteE = 1; WriteRegE = 31;
        step("jr_alu_in_e", mk(1, 0, 0, 0));

        clr(); MdStartE = 1; MdIsDivE = 1; HiLoReadD = 1;
        step("div_issue_mflo_stall", mk(1, 0, 0, 0));
        for (int k = 1; k <= 32; k++) begin
            clr(); HiLoReadD = 1;
            step($sformatf("div_cyc%0d", k), mk(1, 0, 1, k == 32));
        end
        clr(); HiLoReadD = 1;
        step("mflo_after_done", mk(0, 0, 0, 0));

        clr(); MdStartE = 1;
        step("mult1_issue", mk(0, 0, 0, 0));
        for (int k = 1; k <= 9; k++) begin
            clr();
            if (k == 2 || k == 6) begin MdStartE = 1; MdIsDivE = 1; end
            if (k == 4) MdStartE = 1;
            if (k == 5) MdStartD = 1;
            step($sformatf("b2b_cyc%0d", k), mk(k == 5, 0, k != 9, k == 4 || k == 8));
        end

        clr(); MdStartE = 1; MdIsDivE = 1;
        step("div2_issue", mk(0, 0, 0, 0));
        for (int k = 1; k <= 9; k++) begin
            clr();
            step($sformatf("div2_cyc%0d", k), mk(0, 0, 1, 0));
        end
        clr(); rst = 1; lw_hazard(7); HiLoReadD = 1; PCSrcD = 1;
        step("rst_mid_div", mk(0, 0, 1, 0));
        rst = 0;
        for (int k = 1; k <= 30; k++) begin
            clr(); HiLoReadD = 1;
            step($sformatf("after_rst%0d", k), mk(0, 0, 0, 0));
        end

`ifdef HAZARD_PERF_EN
        clr(); rst = 1;
        step("perf_rst", mk(0, 0, 0, 0));
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            clr(); lw_hazard(3);
            step("perf_lw", mk(1, 0, 0, 0));
            clr();
            step("perf_gap", mk(0, 0, 0, 0));
        end
        for (int k = 0; k < 2; k++) begin
            clr(); PCSrcD = 1;
            step("perf_br", mk(0, 1, 0, 0));
        end
        clr();
        checks++;
        assert (StallCnt === 32'd3) else begin
            errors++;
            $error("FAIL stall_cnt observed=%0d expected=3", StallCnt);
        end
        checks++;
        assert (FlushCnt === 32'd2) else begin
            errors++;
            $error("FAIL flush_cnt observed=%0d expected=2", FlushCnt);
        end
        rst = 1;
        step("perf_rst2", mk(0, 0, 0, 0));
        rst = 0;
        checks++;
        assert (StallCnt === 32'd0 && FlushCnt === 32'd0) else begin
            errors++;
            $error("FAIL perf_clear observed=%0d/%0d expected=0/0", StallCnt, FlushCnt);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
